// File: rtl/acq_sequencer.sv
// acq_sequencer: runs SAMPLES signal-channel then SAMPLES noise-channel ADC conversions,
// then launches the comparator. Define ACQ_TIMEOUT_EN to add the wait-state watchdog.
module acq_sequencer #(
  parameter int SAMPLES     = 2,
  parameter int CNT_W       = 10,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             adc_eoc,
  input  logic             complete_comparator,
  output logic             adc_soc,
  output logic             adc_chan_sel,
  output logic             done_signal,
  output logic             done_noise,
  output logic             start_comparator,
  output logic             busy,
  output logic             seq_done,
  output logic [CNT_W-1:0] sample_idx,
  output logic             err_timeout
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SOC       = 3'd1;
  localparam logic [2:0] S_WAIT_EOC  = 3'd2;
  localparam logic [2:0] S_CMP_START = 3'd3;
  localparam logic [2:0] S_CMP_WAIT  = 3'd4;
  localparam logic [2:0] S_FINISH    = 3'd5;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES - 1);
  localparam logic [CNT_W-1:0] FULL_IDX = CNT_W'(SAMPLES);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             chan_q, chan_d;
  logic             done_sig_q, done_sig_d;
  logic             done_noise_q, done_noise_d;
  logic             err_q, err_d;
  logic             sync1_q, sync2_q, eoc_prev_q;
  logic             eoc_rise;
  logic             timeout_hit;

  // Two flops settle the asynchronous EOC; the third remembers the last settled level.
  // NOTE: sequential state uses non-blocking assignments and the async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      eoc_prev_q <= 1'b0;
    end else begin
      sync1_q    <= adc_eoc;
      sync2_q    <= sync1_q;
      eoc_prev_q <= sync2_q;
    end
  end

  assign eoc_rise = sync2_q & ~eoc_prev_q;

`ifdef ACQ_TIMEOUT_EN
  localparam int               WD_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            in_wait;

  assign in_wait     = (state_q == S_WAIT_EOC) || (state_q == S_CMP_WAIT);
  assign timeout_hit = in_wait && (wd_q == WD_LAST);

  // Restarts from zero whenever a wait state is entered or left.
  always_comb begin
    wd_d = '0;
    if (in_wait && (state_d == state_q)) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    chan_d       = chan_q;
    done_sig_d   = done_sig_q;
    done_noise_d = done_noise_q;
    err_d        = err_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      idx_d        = '0;
      chan_d       = 1'b0;
      done_sig_d   = 1'b0;
      done_noise_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            idx_d        = '0;
            chan_d       = 1'b0;
            done_sig_d   = 1'b0;
            done_noise_d = 1'b0;
            err_d        = 1'b0;
            state_d      = S_SOC;
          end
        end
        S_SOC:       state_d = S_WAIT_EOC;
        S_WAIT_EOC: begin
          // The awaited event is tested first so it wins over a same-cycle expiry.
          if (eoc_rise) begin
            if (idx_q == LAST_IDX) begin
              if (!chan_q) begin
                done_sig_d = 1'b1;
                chan_d     = 1'b1;
                idx_d      = '0;
                state_d    = S_SOC;
              end else begin
                done_noise_d = 1'b1;
                idx_d        = FULL_IDX;
                state_d      = S_CMP_START;
              end
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_SOC;
            end
          end else if (timeout_hit) begin
            err_d        = 1'b1;
            done_sig_d   = 1'b0;
            done_noise_d = 1'b0;
            state_d      = S_IDLE;
          end
        end
        S_CMP_START: state_d = S_CMP_WAIT;
        S_CMP_WAIT: begin
          if (complete_comparator) begin
            state_d = S_FINISH;
          end else if (timeout_hit) begin
            err_d        = 1'b1;
            done_sig_d   = 1'b0;
            done_noise_d = 1'b0;
            state_d      = S_IDLE;
          end
        end
        S_FINISH:    state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      chan_q       <= 1'b0;
      done_sig_q   <= 1'b0;
      done_noise_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      chan_q       <= chan_d;
      done_sig_q   <= done_sig_d;
      done_noise_q <= done_noise_d;
      err_q        <= err_d;
    end
  end

  // Pulses are suppressed in an abort cycle so nothing is launched on the way out.
  assign adc_soc          = (state_q == S_SOC) && !abort;
  assign start_comparator = (state_q == S_CMP_START) && !abort;
  assign seq_done         = (state_q == S_FINISH) && !abort;
  assign busy             = (state_q != S_IDLE);
  assign adc_chan_sel     = chan_q;
  assign done_signal      = done_sig_q;
  assign done_noise       = done_noise_q;
  assign sample_idx       = idx_q;
  assign err_timeout      = err_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: a SAMPLES=2 instance and a SAMPLES=1 instance
// (TIMEOUT_CYC=16); expected pulses are queued at stimulus time and popped by a monitor.
module tb_acq_sequencer;
  localparam int CNT_W = 10;
  localparam logic [1:0] K_SOC  = 2'd1;
  localparam logic [1:0] K_CMP  = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  typedef struct packed {
    logic [1:0]       kind;
    logic             chan;
    logic [CNT_W-1:0] idx;
    logic             ds;
    logic             dn;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start2 = 1'b0, abort2 = 1'b0, eoc2 = 1'b0, cc2 = 1'b0;
  logic soc2, chan2, ds2, dn2, cmp2, busy2, done2, err2;
  logic [CNT_W-1:0] idx2;
  logic start1 = 1'b0, abort1 = 1'b0, eoc1 = 1'b0, cc1 = 1'b0;
  logic soc1, chan1, ds1, dn1, cmp1, busy1, done1, err1;
  logic [CNT_W-1:0] idx1;

  acq_sequencer #(.SAMPLES(2), .CNT_W(CNT_W), .TIMEOUT_CYC(1024)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .adc_eoc(eoc2),
    .complete_comparator(cc2), .adc_soc(soc2), .adc_chan_sel(chan2),
    .done_signal(ds2), .done_noise(dn2), .start_comparator(cmp2), .busy(busy2),
    .seq_done(done2), .sample_idx(idx2), .err_timeout(err2));

  acq_sequencer #(.SAMPLES(1), .CNT_W(CNT_W), .TIMEOUT_CYC(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .adc_eoc(eoc1),
    .complete_comparator(cc1), .adc_soc(soc1), .adc_chan_sel(chan1),
    .done_signal(ds1), .done_noise(dn1), .start_comparator(cmp1), .busy(busy1),
    .seq_done(done1), .sample_idx(idx1), .err_timeout(err1));

  int  vectors     = 0;
  int  miscompares = 0;
  ev_t q2[$];
  ev_t q1[$];
  ev_t obs2, obs1;
  int  ev_n2 = 0, ev_n1 = 0;
  bit  train_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic [1:0] k, input logic c, input int i,
                             input logic s, input logic n);
    ev_t e;
    e.kind = k; e.chan = c; e.idx = CNT_W'(i); e.ds = s; e.dn = n;
    return e;
  endfunction

  // Monitor: every pulse on either DUT must match the head of its expectation queue.
  always @(negedge clk) begin
    if (rst_n && (soc2 || cmp2 || done2)) begin
      obs2 = mk(soc2 ? K_SOC : (cmp2 ? K_CMP : K_DONE), chan2, int'(idx2), ds2, dn2);
      if (q2.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL dut2 unexpected event: got %h expected none", obs2);
      end else check($sformatf("dut2 event %0d", ev_n2), 32'(obs2), 32'(q2.pop_front()));
      ev_n2++;
    end
    if (rst_n && (soc1 || cmp1 || done1)) begin
      obs1 = mk(soc1 ? K_SOC : (cmp1 ? K_CMP : K_DONE), chan1, int'(idx1), ds1, dn1);
      if (q1.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL dut1 unexpected event: got %h expected none", obs1);
      end else check($sformatf("dut1 event %0d", ev_n1), 32'(obs1), 32'(q1.pop_front()));
      ev_n1++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return cmp2;
      1:       return done2;
      2:       return (idx2 == CNT_W'(1));
      3:       return ds2 && (idx2 == CNT_W'(1));
      4:       return cmp1;
      5:       return done1;
      6:       return err1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string name, output int cycles);
    cycles = 0;
    while (!probe(sel) && cycles < budget) begin
      tick();
      cycles++;
    end
    check({name, " seen"}, 32'(probe(sel)), 32'd1);
  endtask

  task automatic eoc_train(input bit to_dut1, input int n, input int hold, input int gap);
    train_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (to_dut1) eoc1 = 1'b1;
      else         eoc2 = 1'b1;
      repeat (hold) tick();
      eoc1 = 1'b0;
      eoc2 = 1'b0;
      repeat (gap) tick();
    end
    train_busy = 1'b0;
  endtask

  task automatic push_full_run2();
    q2.push_back(mk(K_SOC,  1'b0, 0, 1'b0, 1'b0));
    q2.push_back(mk(K_SOC,  1'b0, 1, 1'b0, 1'b0));
    q2.push_back(mk(K_SOC,  1'b1, 0, 1'b1, 1'b0));
    q2.push_back(mk(K_SOC,  1'b1, 1, 1'b1, 1'b0));
    q2.push_back(mk(K_CMP,  1'b1, 2, 1'b1, 1'b1));
    q2.push_back(mk(K_DONE, 1'b1, 2, 1'b1, 1'b1));
  endtask

  task automatic run2(input string tag, input int hold, input int gap, input bit poke);
    int cyc;
    push_full_run2();
    start2 = 1'b1; tick(); start2 = 1'b0; tick();
    fork
      eoc_train(1'b0, 4, hold, gap);
    join_none
    if (poke) begin
      wait_for(2, 60, {tag, " idx1"}, cyc);
      start2 = 1'b1; tick(); start2 = 1'b0;
      check({tag, " start in WAIT_EOC idx"}, 32'(idx2), 32'd1);
      check({tag, " start in WAIT_EOC busy"}, 32'(busy2), 32'd1);
    end
    wait_for(0, 400, {tag, " start_comparator"}, cyc);
    if (poke) begin
      tick();
      start2 = 1'b1; tick(); start2 = 1'b0;
      check({tag, " start in CMP_WAIT idx"}, 32'(idx2), 32'd2);
      repeat (3) tick();
    end else begin
      repeat (5) tick();
    end
    cc2 = 1'b1;
    wait_for(1, 20, {tag, " seq_done"}, cyc);
    tick();
    cc2 = 1'b0;
    check({tag, " flags after run"}, 32'({ds2, dn2, busy2}), 32'b110);
    while (train_busy) tick();
    repeat (3) tick();
  endtask

  initial begin
    #400000;
    $display("FAIL sim_watchdog: got no finish, expected finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs dut2", 32'({soc2, chan2, ds2, dn2, cmp2, busy2, done2, err2, idx2}), 32'd0);
    check("reset outputs dut1", 32'({soc1, chan1, ds1, dn1, cmp1, busy1, done1, err1, idx1}), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle after reset", 32'({busy2, busy1, idx2}), 32'd0);

    // Basic run, then EOC held high for 20 clk per conversion, then start pokes while busy.
    run2("t1", 1, 3, 1'b0);
    run2("t2", 20, 3, 1'b0);
    run2("t3", 1, 10, 1'b1);

    // Abort once the fourth conversion has been launched.
    q2.push_back(mk(K_SOC, 1'b0, 0, 1'b0, 1'b0));
    q2.push_back(mk(K_SOC, 1'b0, 1, 1'b0, 1'b0));
    q2.push_back(mk(K_SOC, 1'b1, 0, 1'b1, 1'b0));
    q2.push_back(mk(K_SOC, 1'b1, 1, 1'b1, 1'b0));
    start2 = 1'b1; tick(); start2 = 1'b0; tick();
    fork
      eoc_train(1'b0, 3, 1, 3);
    join_none
    wait_for(3, 60, "t4 fourth soc", cyc);
    tick();
    abort2 = 1'b1; tick(); abort2 = 1'b0;
    check("t4 after abort", 32'({busy2, ds2, dn2, chan2, idx2}), 32'd0);
    while (train_busy) tick();
    repeat (8) tick();
    check("t4 stays idle", 32'(busy2), 32'd0);

    // Asynchronous reset in the middle of a run.
    q2.push_back(mk(K_SOC, 1'b0, 0, 1'b0, 1'b0));
    start2 = 1'b1; tick(); start2 = 1'b0; tick();
    #2 rst_n = 1'b0;
    #1 check("async reset mid-run", 32'({soc2, chan2, ds2, dn2, cmp2, busy2, done2, idx2}), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // SAMPLES=1: start with abort is dropped, then a full run.
    start1 = 1'b1; abort1 = 1'b1; tick(); start1 = 1'b0; abort1 = 1'b0;
    check("t5 start+abort idle", 32'(busy1), 32'd0);
    tick();
    check("t5 still idle", 32'(busy1), 32'd0);
    q1.push_back(mk(K_SOC,  1'b0, 0, 1'b0, 1'b0));
    q1.push_back(mk(K_SOC,  1'b1, 0, 1'b1, 1'b0));
    q1.push_back(mk(K_CMP,  1'b1, 1, 1'b1, 1'b1));
    q1.push_back(mk(K_DONE, 1'b1, 1, 1'b1, 1'b1));
    start1 = 1'b1; tick(); start1 = 1'b0; tick();
    fork
      eoc_train(1'b1, 2, 1, 3);
    join_none
    wait_for(4, 100, "t5 start_comparator", cyc);
    repeat (5) tick();
    cc1 = 1'b1;
    wait_for(5, 20, "t5 seq_done", cyc);
    tick();
    cc1 = 1'b0;
    check("t5 flags after run", 32'({ds1, dn1, busy1, idx1}), 32'({3'b110, CNT_W'(1)}));
    while (train_busy) tick();
    repeat (3) tick();

    // No EOC after the first conversion request.
    q1.push_back(mk(K_SOC, 1'b0, 0, 1'b0, 1'b0));
    start1 = 1'b1; tick(); start1 = 1'b0;
`ifdef ACQ_TIMEOUT_EN
    wait_for(6, 40, "t6 err_timeout", cyc);
    check("t6 expiry cycle", 32'(cyc), 32'd17);
    check("t6 idle after expiry", 32'({busy1, ds1, dn1}), 32'd0);
    repeat (3) tick();
    check("t6 err sticky", 32'(err1), 32'd1);
    q1.push_back(mk(K_SOC, 1'b0, 0, 1'b0, 1'b0));
    start1 = 1'b1; tick(); start1 = 1'b0;
    check("t6 err cleared by start", 32'(err1), 32'd0);
    tick();
    abort1 = 1'b1; tick(); abort1 = 1'b0;
`else
    repeat (1000) tick();
    check("t6 waiting after 1000 clk", 32'({busy1, err1}), 32'b10);
    abort1 = 1'b1; tick(); abort1 = 1'b0;
`endif
    check("t6 idle at end", 32'(busy1), 32'd0);

    repeat (5) tick();
    check("dut2 expectations drained", 32'(q2.size()), 32'd0);
    check("dut1 expectations drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
